// File: rtl/arm_mc_pkg.sv
// rtl/arm_mc_pkg.sv - shared types, encodings and decode helpers for the multicycle ARM control unit.
// Optional MOV/LSL decode is enabled by defining ARM_LSL_EN.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNDEF    = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_LSL = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_LSL = 3'd4;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  typedef struct packed {
    logic       next_pc;
    logic       branch;
    logic       reg_w;
    logic       mem_w;
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       alu_dec;
  } ctrl_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] alu;
    logic       no_write;
    logic       upd_cv;
  } dp_dec_t;

  function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
    dp_dec_t d;
    d.valid    = 1'b1;
    d.alu      = ALU_ADD;
    d.no_write = 1'b0;
    d.upd_cv   = 1'b0;
    case (cmd)
      CMD_ADD: d.upd_cv = 1'b1;
      CMD_SUB: begin d.alu = ALU_SUB; d.upd_cv = 1'b1; end
      CMD_AND: d.alu = ALU_AND;
      CMD_ORR: d.alu = ALU_ORR;
      CMD_CMP: begin d.alu = ALU_SUB; d.no_write = 1'b1; d.upd_cv = 1'b1; end
      CMD_TST: begin d.alu = ALU_AND; d.no_write = 1'b1; end
`ifdef ARM_LSL_EN
      CMD_LSL: d.alu = ALU_LSL;
`endif
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  // Raw per-state controls; 'last' marks the final cycle of a wait-stated state.
  function automatic ctrl_t state_ctrl(input state_t s, input logic last);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = last;
        c.next_pc    = last;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      S_MEMADR: begin
        c.alu_src_b = SRCB_EXTIMM;
        c.imm_src   = IMM_12;
      end
      S_MEMREAD: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
      end
      S_MEMWRITE: begin
        c.adr_src    = 1'b1;
        c.result_src = RES_ALUOUT;
        c.mem_w      = last;
      end
      S_MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_b = SRCB_RD2;
        c.alu_dec   = 1'b1;
      end
      S_EXECUTEI: begin
        c.alu_src_b = SRCB_EXTIMM;
        c.imm_src   = IMM_8;
        c.alu_dec   = 1'b1;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_b  = SRCB_EXTIMM;
        c.imm_src    = IMM_24;
        c.result_src = RES_ALURESULT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arm_mc_condcheck.sv
// rtl/arm_mc_condcheck.sv - NZCV flags register with per-group enables and condition evaluation.
module arm_mc_condcheck
  import arm_mc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_upd_nz,
  input  logic       i_upd_cv,
  output logic       o_cond_ex
);

  logic [3:0] r_flags;
  logic       w_n, w_z, w_c, w_v, w_ge;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags <= 4'b0000;
    end else begin
      if (i_upd_nz) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_upd_cv) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  assign {w_n, w_z, w_c, w_v} = r_flags;
  assign w_ge = (w_n == w_v);

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// rtl/arm_mc_controller.sv - multicycle ARM control FSM with memory wait states and registered controls.
// Define ARM_LSL_EN to decode cmd 1101 as MOV/LSL instead of trapping to UNDEF.
module arm_mc_controller
  import arm_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int MEM_WAIT  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [3:0]           state_o
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     r_state;
  logic [3:0] r_cnt;
  ctrl_t      r_ctrl;
  logic [2:0] r_alu;
  logic       r_cond_hold;

  state_t     w_state_nxt;
  logic [3:0] w_cnt_nxt;
  ctrl_t      w_ctrl_nxt;
  logic [3:0] w_cond, w_cmd, w_rd;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  dp_dec_t    w_dp;
  logic       w_last, w_exec, w_cond_ex, w_cond_use, w_pcs;
  logic       w_upd_nz, w_upd_cv;
  logic [3:0] w_unused_rn;

  assign w_cond      = Instr[19:16];
  assign w_op        = Instr[15:14];
  assign w_funct     = Instr[13:8];
  assign w_unused_rn = Instr[7:4];
  assign w_rd        = Instr[3:0];
  assign w_cmd       = w_funct[4:1];
  assign w_dp        = dp_decode(w_cmd);
  assign w_last      = (r_cnt == WAIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:    if (w_last) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_MEM:  w_state_nxt = S_MEMADR;
          OP_BR:   w_state_nxt = S_BRANCH;
          OP_DP: begin
            if (!w_dp.valid)     w_state_nxt = S_UNDEF;
            else if (w_funct[5]) w_state_nxt = S_EXECUTEI;
            else                 w_state_nxt = S_EXECUTER;
          end
          default: w_state_nxt = S_UNDEF;
        endcase
      end
      S_MEMADR:   w_state_nxt = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (w_last) w_state_nxt = S_MEMWB;
      S_MEMWRITE: if (w_last) w_state_nxt = S_FETCH;
      S_EXECUTER, S_EXECUTEI: w_state_nxt = w_dp.no_write ? S_FETCH : S_ALUWB;
      default:    w_state_nxt = S_FETCH;
    endcase
  end

  // Counter restarts on every state change so each wait-stated entry gets a full MEM_WAIT+1 cycles.
  assign w_cnt_nxt  = (w_state_nxt != r_state) ? 4'd0 : r_cnt + 4'd1;
  assign w_ctrl_nxt = state_ctrl(w_state_nxt, w_cnt_nxt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_cnt       <= 4'd0;
      r_ctrl      <= state_ctrl(S_FETCH, WAIT_LAST == 4'd0);
      r_alu       <= ALU_ADD;
      r_cond_hold <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ctrl  <= w_ctrl_nxt;
      r_alu   <= w_ctrl_nxt.alu_dec ? w_dp.alu : ALU_ADD;
      if (w_exec) r_cond_hold <= w_cond_ex;
    end
  end

  assign w_exec   = (r_state == S_EXECUTER) || (r_state == S_EXECUTEI);
  assign w_upd_nz = w_exec & w_funct[0] & w_cond_ex & w_dp.valid;
  assign w_upd_cv = w_upd_nz & w_dp.upd_cv;

  arm_mc_condcheck u_condcheck (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_cond      (w_cond),
    .i_alu_flags (ALUFlags),
    .i_upd_nz    (w_upd_nz),
    .i_upd_cv    (w_upd_cv),
    .o_cond_ex   (w_cond_ex)
  );

  // ALUWB must use the verdict taken before its own EXECUTE updated the flags.
  assign w_cond_use = (r_state == S_ALUWB) ? r_cond_hold : w_cond_ex;
  assign w_pcs      = r_ctrl.branch | (r_ctrl.reg_w & (w_rd == 4'hF));

  assign PCWrite    = r_ctrl.next_pc | (w_pcs & w_cond_use & ~reset);
  assign MemWrite   = r_ctrl.mem_w & w_cond_use & ~reset;
  assign RegWrite   = r_ctrl.reg_w & w_cond_use & ~reset;
  assign IRWrite    = r_ctrl.ir_write;
  assign AdrSrc     = r_ctrl.adr_src;
  assign ResultSrc  = r_ctrl.result_src;
  assign ALUSrcA    = r_ctrl.alu_src_a;
  assign ALUSrcB    = r_ctrl.alu_src_b;
  assign ImmSrc     = r_ctrl.imm_src;
  assign ALUControl = ALUCTRL_W'(r_alu);
  assign RegSrc     = {w_op == OP_MEM, w_op == OP_BR};
  assign state_o    = r_state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// tb/tb_arm_mc_controller.sv - scoreboard bench for arm_mc_controller with MEM_WAIT 0 and 2 instances.
module tb_arm_mc_controller;
  import arm_mc_pkg::*;

  typedef struct {
    bit          sel;
    logic [14:0] exp;
    logic [14:0] mask;
    int          id;
    string       nm;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] instr = 20'h0;
  logic [3:0]  alu_flags = 4'h0;

  logic       pcw [2];
  logic       memw [2];
  logic       irw [2];
  logic       regw [2];
  logic [1:0] rs [2];
  logic [1:0] srcb [2];
  logic [2:0] aluc [2];
  logic [3:0] st [2];
  logic       unused_adr [2];
  logic       unused_srca [2];
  logic [1:0] unused_imm [2];
  logic [1:0] unused_regsrc [2];

  chk_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step = 0;

  always #5 clk = ~clk;

  arm_mc_controller #(.ALUCTRL_W(3), .MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(pcw[0]), .AdrSrc(unused_adr[0]), .MemWrite(memw[0]), .IRWrite(irw[0]),
    .RegWrite(regw[0]), .ResultSrc(rs[0]), .ALUSrcA(unused_srca[0]), .ALUSrcB(srcb[0]),
    .ALUControl(aluc[0]), .ImmSrc(unused_imm[0]), .RegSrc(unused_regsrc[0]), .state_o(st[0])
  );

  arm_mc_controller #(.ALUCTRL_W(3), .MEM_WAIT(2)) u_dut2 (
    .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
    .PCWrite(pcw[1]), .AdrSrc(unused_adr[1]), .MemWrite(memw[1]), .IRWrite(irw[1]),
    .RegWrite(regw[1]), .ResultSrc(rs[1]), .ALUSrcA(unused_srca[1]), .ALUSrcB(srcb[1]),
    .ALUControl(aluc[1]), .ImmSrc(unused_imm[1]), .RegSrc(unused_regsrc[1]), .state_o(st[1])
  );

  function automatic logic [14:0] act_vec(input int d);
    return {st[d], pcw[d], memw[d], irw[d], regw[d], rs[d], srcb[d], aluc[d]};
  endfunction

  // Monitor: one comparison per cycle whenever an expectation is queued.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        chk_t        c;
        logic [14:0] a;
        c = q.pop_front();
        a = act_vec(c.sel ? 1 : 0);
        total++;
        if ((a & c.mask) !== (c.exp & c.mask)) begin
          bad++;
          $display("FAIL %s step %0d: got %h want %h (mask %h)", c.nm, c.id, a, c.exp, c.mask);
        end
      end
    end
  end

  // Queue the expected outputs for the current cycle, then advance one cycle.
  task automatic expect_cyc(input bit sel, input string nm, input logic [3:0] s,
                            input logic pc, input logic mw, input logic ir, input logic rw,
                            input logic [2:0] ac);
    chk_t       c;
    logic [1:0] ers, esb;
    logic [6:0] fmask;
    ers = 2'b00; esb = 2'b00; fmask = 7'b0;
    case (s)
      S_FETCH, S_DECODE: begin ers = 2'b10; esb = 2'b10; fmask = 7'h7F; end
      S_MEMADR:          begin esb = 2'b01; fmask = 7'b0011111; end
      S_EXECUTER:        begin esb = 2'b00; fmask = 7'b0011111; end
      S_EXECUTEI:        begin esb = 2'b01; fmask = 7'b0011111; end
      S_BRANCH:          begin ers = 2'b10; esb = 2'b01; fmask = 7'h7F; end
      S_ALUWB:           begin ers = 2'b00; fmask = 7'b1100000; end
      S_MEMWB:           begin ers = 2'b01; fmask = 7'b1100000; end
      default:           fmask = 7'b0;
    endcase
    step++;
    c.sel  = sel;
    c.exp  = {s, pc, mw, ir, rw, ers, esb, ac};
    c.mask = {8'hFF, fmask};
    c.id   = step;
    c.nm   = nm;
    q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [19:0] ins);
    reset = 1'b1;
    instr = ins;
    alu_flags = 4'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // ADD R2,R0,#5 then CMP R0,#5 then BEQ
    do_reset(20'hE2802);
    expect_cyc(0, "rst_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "add_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "add_exi",   S_EXECUTEI, 0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "add_wb",    S_ALUWB,    0, 0, 0, 1, ALU_ADD);
    instr = 20'hE3500; alu_flags = 4'b0100;
    expect_cyc(0, "cmp_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "cmp_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "cmp_exi",   S_EXECUTEI, 0, 0, 0, 0, ALU_SUB);
    instr = 20'h0A000; alu_flags = 4'b0000;
    expect_cyc(0, "cmp_nowb",  S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "beq_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "beq_taken", S_BRANCH,   1, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "beq_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);

    // BEQ with Z clear, then STR interrupted by reset in MEMWRITE, then a clean STR
    do_reset(20'h0A000);
    expect_cyc(0, "bz_fetch",  S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "bz_dec",    S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "bz_ntaken", S_BRANCH,   0, 0, 0, 0, ALU_ADD);
    instr = 20'hE5801;
    expect_cyc(0, "str_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "str_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "str_adr",   S_MEMADR,   0, 0, 0, 0, ALU_ADD);
    reset = 1'b1;
    expect_cyc(0, "str_rst",   S_MEMWRITE, 0, 0, 0, 0, ALU_ADD);
    reset = 1'b0;
    expect_cyc(0, "rst_refet", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "str2_dec",  S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "str2_adr",  S_MEMADR,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "str2_mw",   S_MEMWRITE, 0, 1, 0, 0, ALU_ADD);
    expect_cyc(0, "str2_fet",  S_FETCH,    1, 0, 1, 0, ALU_ADD);

    // ADDEQ with Z clear, ADDNV, and ADD to PC
    do_reset(20'h02802);
    expect_cyc(0, "aeq_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "aeq_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "aeq_exi",   S_EXECUTEI, 0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "aeq_wb",    S_ALUWB,    0, 0, 0, 0, ALU_ADD);
    instr = 20'hF2802;
    expect_cyc(0, "anv_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "anv_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "anv_exi",   S_EXECUTEI, 0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "anv_wb",    S_ALUWB,    0, 0, 0, 0, ALU_ADD);
    instr = 20'hE280F;
    expect_cyc(0, "apc_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "apc_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "apc_exi",   S_EXECUTEI, 0, 0, 0, 0, ALU_ADD);
    expect_cyc(0, "apc_wb",    S_ALUWB,    1, 0, 0, 1, ALU_ADD);
    expect_cyc(0, "apc_fet",   S_FETCH,    1, 0, 1, 0, ALU_ADD);

    // MOV/LSL
    do_reset(20'hE1A00);
    expect_cyc(0, "lsl_fetch", S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(0, "lsl_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
`ifdef ARM_LSL_EN
    expect_cyc(0, "lsl_exr",   S_EXECUTER, 0, 0, 0, 0, ALU_LSL);
    expect_cyc(0, "lsl_wb",    S_ALUWB,    0, 0, 0, 1, ALU_ADD);
`else
    expect_cyc(0, "lsl_undef", S_UNDEF,    0, 0, 0, 0, ALU_ADD);
`endif
    expect_cyc(0, "lsl_fet",   S_FETCH,    1, 0, 1, 0, ALU_ADD);

    // LDR on the MEM_WAIT=2 instance
    do_reset(20'hE5901);
    expect_cyc(1, "ldr_f0",    S_FETCH,    0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_f1",    S_FETCH,    0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_f2",    S_FETCH,    1, 0, 1, 0, ALU_ADD);
    expect_cyc(1, "ldr_dec",   S_DECODE,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_adr",   S_MEMADR,   0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_r0",    S_MEMREAD,  0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_r1",    S_MEMREAD,  0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_r2",    S_MEMREAD,  0, 0, 0, 0, ALU_ADD);
    expect_cyc(1, "ldr_wb",    S_MEMWB,    0, 0, 0, 1, ALU_ADD);
    expect_cyc(1, "ldr_fet",   S_FETCH,    0, 0, 0, 0, ALU_ADD);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
Control unit for the next-generation multicycle ARMv4-subset core. It replaces the single-cycle decoder and condition-logic path with a registered FSM that sequences one shared memory port, one ALU and the register file over several cycles per instruction. It adds programmable memory wait states, a parametrised ALU-control width, native CMP/TST with no register write-back, and an undefined-instruction recovery path. It sits between the fetched instruction register and the multicycle datapath.

Parameters:
ALUCTRL_W, 3, ALUControl width; must be >= 3 when ARM_LSL_EN is defined.
MEM_WAIT, 0, extra wait cycles the shared memory needs in FETCH, MEMREAD and MEMWRITE (0..15).

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high reset.
Instr  in  20  Instr[31:12] from the instruction register.
ALUFlags  in  4  {N,Z,C,V} from the ALU this cycle.
PCWrite  out  1  load PC.
AdrSrc  out  1  memory address: 0 = PC, 1 = Result.
MemWrite  out  1  data memory write strobe.
IRWrite  out  1  load instruction register.
RegWrite  out  1  register file write.
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
ALUSrcA  out  1  0 = RD1, 1 = PC.
ALUSrcB  out  2  00 RD2, 01 ExtImm, 10 constant 4.
ALUControl  out  ALUCTRL_W  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LSL.
ImmSrc  out  2  00 imm8, 01 imm12, 10 branch imm24.
RegSrc  out  2  register-address source selects, same meaning as in the single-cycle core.
state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset, synchronous: state goes to FETCH, the wait counter and the Flags register clear to 0. On the first cycle after reset all write strobes are 0 except the FETCH-cycle strobes.
- States and transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR when Op = 01.
  - DECODE -> EXECUTEI when Op = 00 and Funct[5] = 1; DECODE -> EXECUTER when Op = 00 and Funct[5] = 0.
  - DECODE -> BRANCH when Op = 10.
  - DECODE -> UNDEF when Op = 11 or the cmd is unsupported.
  - MEMADR -> MEMREAD when L = 1, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB, then FETCH. CMP and TST skip ALUWB and go straight to FETCH.
  - BRANCH -> FETCH. UNDEF -> FETCH.
- Wait states: FETCH, MEMREAD and MEMWRITE each last MEM_WAIT+1 cycles, counted by a 4-bit counter. IRWrite, PCWrite and MemWrite assert only in the last cycle of their state. The counter reloads on every entry to one of these states.
- FETCH: AdrSrc 0, ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10.
- DECODE: same ALU setup as FETCH, so ALUOut holds PC+8.
- MEMADR: ALUSrcA 0, ALUSrcB 01, ImmSrc 01, ADD.
- EXECUTER: ALUSrcB 00. EXECUTEI: ALUSrcB 01, ImmSrc 00.
- BRANCH: ALUSrcA 0, ALUSrcB 01, ImmSrc 10, ADD, ResultSrc 10.
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite), 1000 TST (AND, NoWrite).
- Condition check: CondEx is computed from the registered Flags and Cond[3:0], using the standard 14 codes. 1110 gives 1; 1111 gives 0.
- Gating: RegWrite = RegW & CondEx. MemWrite = MemW & CondEx. PCWrite = NextPC | (PCS & CondEx). PCS = Branch, or Rd = 15 in ALUWB or MEMWB.
- Flags update: in the EXECUTE states only, at the clock edge ending that cycle, when S = 1 and CondEx = 1.
  - NZ update for every DP cmd.
  - CV update for ADD, SUB and CMP only.
- UNDEF: asserts no strobes for one cycle, then returns to FETCH. PC has already advanced, so the instruction acts as a NOP.
- Reset in any state, including mid-wait: the next cycle is FETCH with the counter at 0. No pending MemWrite or RegWrite occurs.

Optional Feature:
ARM_LSL_EN:
- Defined: cmd 1101 (MOV/LSL) is decoded to ALUControl 4 with NZ flag update.
- Undefined: cmd 1101 goes to UNDEF. ALUControl never takes the value 4.

Decomposition:
- Package arm_mc_pkg holds:
  - the state enum (4 bits);
  - the Op, cmd and Cond constants;
  - the ALUControl constants;
  - the ResultSrc and ALUSrcB constants.
- Sub-module arm_mc_condcheck holds the Flags register (sync reset, per-group enables) and the CondEx evaluation.

Test Plan:
- Reset held 2 cycles, then released -> state_o = FETCH, IRWrite = 1 and PCWrite = 1 in the first cycle (MEM_WAIT = 0), Flags = 0.
- Instr E2802005 (ADD R2,R0,#5) -> states FETCH, DECODE, EXECUTEI, ALUWB. RegWrite = 1 only in cycle 4, with ResultSrc 00.
- MEM_WAIT = 2, Instr E5901004 (LDR) -> FETCH lasts 3 cycles with IRWrite only in the 3rd. MEMREAD lasts 3 cycles. RegWrite in MEMWB with ResultSrc 01.
- Instr E3500005 (CMP) with ALUFlags 0100 -> no ALUWB and no RegWrite. Flags = 0100 afterwards. A following 0A000002 (BEQ) gives PCWrite = 1 in BRANCH.
- Flags Z = 0, Instr 0A000002 -> PCWrite = 0 in BRANCH. E5801004 (STR) with reset asserted in MEMWRITE -> MemWrite never 1, next state FETCH.
- Instr E1A00100 (LSL) -> with ARM_LSL_EN: ALUControl = 4 in EXECUTER. Without it: state UNDEF, no strobes, then FETCH.
